// File: rtl/basemul_readout_ctrl.sv
// Drains RAM C after the core's done edge and streams the N coefficients out
// over valid/ready, using a 2-entry read-ahead buffer to hide the read latency.
module basemul_readout_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             done,
  input  logic             flush,
  output logic             ramc_re,
  output logic [DEPTH-1:0] ramc_addr,
  input  logic [WIDTH-1:0] ramc_dout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             readout,
  output logic             drained
);

  localparam logic [DEPTH:0] ZERO_C = {(DEPTH+1){1'b0}};
  localparam logic [DEPTH:0] ONE_C  = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] N_C    = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] LAST_C = {1'b0, {DEPTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [DEPTH:0]   rd_cnt_r;
  logic [DEPTH:0]   wr_cnt_r;
  logic [1:0]       occ_r;
  logic             inflight_r;
  logic             done_q_r;
  logic             readout_r;
  logic             drained_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic             start_s;
  logic             pop_s;
  logic             push_s;
  logic             issue_s;
  logic [2:0]       pend_s;

  assign out_valid = (occ_r != 2'd0);
  assign out_data  = head_r;
  assign readout   = readout_r;
  assign drained   = drained_r;
  assign ramc_re   = issue_s;
  assign ramc_addr = rd_cnt_r[DEPTH-1:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; flush wins over everything, set=0 freezes
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = IDLE;
    end else if (!set) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) next_state_s = RUN;
          else         next_state_s = IDLE;
        end
        RUN: begin
          if (pop_s && (wr_cnt_r == LAST_C)) next_state_s = DONE;
          else                               next_state_s = RUN;
        end
        DONE:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Read issue and buffer handshake; a same-cycle pop frees a slot for the next read
  always_comb begin
    start_s = done && !done_q_r;
    pop_s   = set && !flush && (state_r == RUN) && out_valid && out_ready;
    push_s  = inflight_r && !flush;
    pend_s  = {1'b0, occ_r} + {2'b00, inflight_r};
    issue_s = 1'b0;
    if (set && !flush && (state_r == RUN) && (rd_cnt_r < N_C)) begin
      issue_s = (pend_s < 3'd2) || (pop_s && (pend_s == 3'd2));
    end else begin
      issue_s = 1'b0;
    end
  end

  // Counters, edge detector and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_r   <= ZERO_C;
      wr_cnt_r   <= ZERO_C;
      inflight_r <= 1'b0;
      done_q_r   <= 1'b0;
      readout_r  <= 1'b0;
      drained_r  <= 1'b0;
    end else if (flush) begin
      rd_cnt_r   <= ZERO_C;
      wr_cnt_r   <= ZERO_C;
      inflight_r <= 1'b0;
      readout_r  <= 1'b0;
      drained_r  <= 1'b0;
      if (set) done_q_r <= done;
    end else begin
      inflight_r <= issue_s;
      if (set) begin
        done_q_r  <= done;
        readout_r <= (next_state_s != IDLE);
        drained_r <= (state_r == DONE);
      end
      if (set && (state_r == IDLE) && start_s) begin
        rd_cnt_r <= ZERO_C;
        wr_cnt_r <= ZERO_C;
      end else begin
        if (issue_s) rd_cnt_r <= rd_cnt_r + ONE_C;
        if (pop_s)   wr_cnt_r <= wr_cnt_r + ONE_C;
      end
    end
  end

  // Two-entry buffer: head drives out_data directly, tail only fills behind it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_r  <= 2'd0;
      head_r <= {WIDTH{1'b0}};
      tail_r <= {WIDTH{1'b0}};
    end else if (flush) begin
      occ_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) head_r <= ramc_dout;
          else               tail_r <= ramc_dout;
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          head_r <= tail_r;
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_r <= ramc_dout;
          end else begin
            head_r <= tail_r;
            tail_r <= ramc_dout;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_basemul_readout_ctrl.sv
// Scoreboard bench for basemul_readout_ctrl: a drain model queues the RAM C
// image on each accepted start, and a negedge monitor checks every transfer.
module tb_basemul_readout_ctrl;
  localparam int DEPTH = 3;
  localparam int WIDTH = 16;
  localparam int N     = 1 << DEPTH;

  logic             clk = 1'b0;
  logic             reset, set, done, flush, out_ready;
  logic             ramc_re, out_valid, readout, drained;
  logic [DEPTH-1:0] ramc_addr;
  logic [WIDTH-1:0] ramc_dout = '0;
  logic [WIDTH-1:0] out_data;

  basemul_readout_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .set(set), .done(done), .flush(flush),
    .ramc_re(ramc_re), .ramc_addr(ramc_addr), .ramc_dout(ramc_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .readout(readout), .drained(drained)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [N];
  logic [WIDTH-1:0] exp_q [$];
  int  n_cmp = 0, n_fail = 0;
  int  issued = 0, xfers = 0, due = 0, since = 0, drains = 0, cyc = 0, ready_mode = 0;
  bit  exp_readout = 0, m_done_q = 0, quiet = 0, prev_stall = 0;
  bit  m_st, m_xf, m_iss;
  logic [WIDTH-1:0] prev_data = '0;

  // RAM C: registered read, data valid the cycle after ramc_re
  always @(posedge clk) if (ramc_re) ramc_dout <= mem[ramc_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model, evaluated mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      issued = 0; xfers = 0; due = 0; since = 0;
      exp_readout = 0; m_done_q = 0; quiet = 0; prev_stall = 0;
    end else begin
      chk("readout", 32'(readout), 32'(exp_readout));
      chk("drained", 32'(drained), 32'(due == 1));
      if (drained) drains++;
      if (quiet) begin
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_re", 32'(ramc_re), 32'd0);
      end
      if (!set) chk("freeze_re", 32'(ramc_re), 32'd0);
      if (!exp_readout) chk("re_when_idle", 32'(ramc_re), 32'd0);
      if (since >= 1 && since <= 2) chk("early_valid", 32'(out_valid), 32'd0);
      if (since == 3) chk("first_valid", 32'(out_valid), 32'd1);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      m_xf  = out_valid && out_ready && set && !flush;
      m_iss = ramc_re && set && !flush;
      if (m_xf) begin
        if (exp_q.size() == 0) chk("spurious_xfer", 32'(out_valid), 32'd0);
        else chk("data", 32'(out_data), 32'(exp_q.pop_front()));
        xfers++;
      end
      if (m_iss) begin
        chk("addr", 32'(ramc_addr), 32'(issued % N));
        chk("read_past_n", 32'(issued < N), 32'd1);
        issued++;
      end
      if (m_iss || m_xf) chk("outstanding", 32'((issued - xfers) <= 2), 32'd1);
      prev_stall = out_valid && !(out_ready && set) && !flush;
      prev_data  = out_data;
      quiet = 0;
      if (since != 0) since = (since == 3) ? 0 : since + 1;
      m_st = set && done && !m_done_q;
      if (set) m_done_q = done;
      if (flush) begin
        exp_readout = 0; exp_q.delete(); due = 0; quiet = 1;
        issued = 0; xfers = 0; since = 0;
      end else if (set) begin
        if (m_st && !exp_readout) begin
          exp_readout = 1;
          for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
          issued = 0; xfers = 0; since = 1;
        end
        if (due == 2) begin
          due = 1; exp_readout = 0;
        end else if (due == 1) begin
          due = 0;
        end
        if (m_xf && xfers == N) due = 2;
      end
    end
  end

  // Sink readiness: always, 1,0,0,1 pattern, or random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit inc);
    for (int i = 0; i < N; i++) mem[i] = inc ? WIDTH'(16'h10 + i) : WIDTH'($urandom);
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(1); done = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while ((exp_readout || due != 0) && k < max) begin tick(1); k++; end
    if (k >= max) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got still draining, required idle within %0d cycles", name, max);
    end
    tick(2);
    chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_xfers(input int n, input int max);
    int k = 0;
    while (xfers < n && k < max) begin tick(1); k++; end
    if (k >= max) begin
      n_cmp++; n_fail++;
      $display("FAIL xfer_wait_timeout: got %0d transfers, required %0d", xfers, n);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_re"}, 32'(ramc_re), 32'd0);
    chk({name, "_addr"}, 32'(ramc_addr), 32'd0);
    chk({name, "_data"}, 32'(out_data), 32'd0);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_readout"}, 32'(readout), 32'd0);
    chk({name, "_drained"}, 32'(drained), 32'd0);
  endtask

  int d0;

  initial begin
    reset = 1'b1; set = 1'b1; done = 1'b0; flush = 1'b0;
    fill(1'b1);
    tick(2);
    chk_zero("reset");
    reset = 1'b0;
    tick(3);

    // basic drain, sink always ready
    d0 = drains; pulse_done(); wait_idle("basic", 40);
    chk("basic_drains", 32'(drains - d0), 32'd1);

    // backpressure pattern 1,0,0,1
    ready_mode = 1; d0 = drains; pulse_done(); wait_idle("backpressure", 80);
    chk("bp_drains", 32'(drains - d0), 32'd1);

    // done held high, then a second rising edge
    ready_mode = 0; fill(1'b0); d0 = drains;
    done = 1'b1; tick(20); done = 1'b0; tick(2);
    done = 1'b1; tick(1); wait_idle("done_held", 60);
    tick(5); done = 1'b0; tick(2);
    chk("held_drains", 32'(drains - d0), 32'd2);

    // flush where the 4th transfer would happen, then restart
    fill(1'b1); d0 = drains; pulse_done();
    wait_xfers(3, 40);
    flush = 1'b1; tick(1); flush = 1'b0; tick(4);
    chk("flush_no_drained", 32'(drains - d0), 32'd0);
    pulse_done(); wait_idle("after_flush", 40);
    chk("flush_restart_drains", 32'(drains - d0), 32'd1);

    // asynchronous reset mid-drain
    pulse_done(); tick(4);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chk_zero("async_reset");
    @(posedge clk); #1;
    reset = 1'b0; d0 = drains;
    tick(6);
    chk("post_reset_drains", 32'(drains - d0), 32'd0);

    // freeze for 3 cycles mid-drain
    fill(1'b0); d0 = drains; pulse_done();
    wait_xfers(3, 40);
    set = 1'b0; tick(3); set = 1'b1;
    wait_idle("freeze", 40);
    chk("freeze_drains", 32'(drains - d0), 32'd1);

    // random data with random sink readiness
    ready_mode = 2;
    repeat (3) begin
      fill(1'b0); d0 = drains; pulse_done(); wait_idle("random", 100);
      chk("random_drains", 32'(drains - d0), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
